// File: rtl/fpmul_result_q_if.sv
// Result-stage bus for fpmul_result_q: issue credit, multiplier completion, consumer valid/ready and status.
interface fpmul_result_q_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  logic                     Start;
  logic                     Start_OK;
  logic                     Done;
  logic [31:0]              P;
  logic                     UF;
  logic                     OF;
  logic                     R_VALID;
  logic                     R_READY;
  logic [31:0]              R_DATA;
  logic                     R_UF;
  logic                     R_OF;
  logic                     R_NAN;
  logic                     R_INF;
  logic                     R_ZERO;
  logic [$clog2(DEPTH):0]   COUNT;
  logic [CNT_W-1:0]         DROP_CNT;
  logic [CNT_W-1:0]         ERR_CNT;

  modport slave (
    input  Start, Done, P, UF, OF, R_READY,
    output Start_OK, R_VALID, R_DATA, R_UF, R_OF, R_NAN, R_INF, R_ZERO,
           COUNT, DROP_CNT, ERR_CNT
  );

  modport master (
    output Start, Done, P, UF, OF, R_READY,
    input  Start_OK, R_VALID, R_DATA, R_UF, R_OF, R_NAN, R_INF, R_ZERO,
           COUNT, DROP_CNT, ERR_CNT
  );
endinterface

// File: rtl/fpmul_result_q.sv
// FP32 multiplier result queue: class-tagged FIFO, start-credit FSM, drop/error counters.
// Optional FPMUL_RQ_BYPASS_EN: same-cycle presentation of a result arriving at an empty queue.
module fpmul_result_q #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  fpmul_result_q_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, WAIT} st_t;

  typedef struct packed {
    logic [31:0] data;
    logic        uf;
    logic        ovf;
    logic        nan;
    logic        inf;
    logic        zero;
  } ent_t;

  function automatic ent_t decode(input logic [31:0] p, input logic uf, input logic ovf);
    ent_t e;
    e.data = p;
    e.uf   = uf;
    e.ovf  = ovf;
    e.nan  = (&p[30:23]) & (|p[22:0]);
    e.inf  = (&p[30:23]) & ~(|p[22:0]);
    e.zero = ~(|p[30:23]);
    return e;
  endfunction

  st_t            st, st_nx;
  ent_t           mem [DEPTH];
  ent_t           hd, hd_nx, in_e, out_e;
  logic [AW-1:0]  rd, wr, rd_nx;
  logic [AW:0]    cnt, cnt_nx, left;
  logic [CNT_W-1:0] drop, err;
  logic [CNT_W:0] err_sum;
  logic [1:0]     err_inc;
  logic           empty, full, pop, push, drop_ev, byp, byp_take, start_ok;

  assign in_e  = decode(bus.P, bus.UF, bus.OF);
  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));

`ifdef FPMUL_RQ_BYPASS_EN
  assign byp = empty & bus.Done;
`else
  assign byp = 1'b0;
`endif

  // A bypassed-and-taken result never touches the array.
  assign byp_take = byp & bus.R_READY;
  assign pop      = ~empty & bus.R_READY;
  assign push     = bus.Done & ~byp_take & (~full | pop);
  assign drop_ev  = bus.Done & full & ~pop;
  assign rd_nx    = rd + AW'(pop);
  assign cnt_nx   = cnt + (AW+1)'(push) - (AW+1)'(pop);
  assign left     = cnt - (AW+1)'(pop);
  assign err_sum  = {1'b0, err} + (CNT_W+1)'(err_inc);

  always_comb begin
    st_nx    = st;
    start_ok = 1'b0;
    err_inc  = 2'd0;
    case (st)
      IDLE: begin
        start_ok = ~full;
        if (bus.Start && start_ok) st_nx = WAIT;
        if (bus.Done) err_inc = err_inc + 2'd1;
      end
      WAIT: if (bus.Done) st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
    if (bus.Start && !start_ok) err_inc = err_inc + 2'd1;
  end

  // Head register: the entry that will sit at the read pointer after this edge.
  always_comb begin
    hd_nx = hd;
    if (byp_take)        hd_nx = in_e;
    else if (left != '0) hd_nx = mem[rd_nx];
    else if (push)       hd_nx = in_e;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= IDLE;
      rd   <= '0;
      wr   <= '0;
      cnt  <= '0;
      hd   <= '0;
      drop <= '0;
      err  <= '0;
    end else begin
      st  <= st_nx;
      rd  <= rd_nx;
      cnt <= cnt_nx;
      hd  <= hd_nx;
      if (push) wr <= wr + AW'(1);
      if (drop_ev && !(&drop)) drop <= drop + CNT_W'(1);
      err <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr] <= in_e;
  end

  assign out_e        = byp ? in_e : hd;
  assign bus.Start_OK = start_ok;
  assign bus.R_VALID  = ~empty | byp;
  assign bus.R_DATA   = out_e.data;
  assign bus.R_UF     = out_e.uf;
  assign bus.R_OF     = out_e.ovf;
  assign bus.R_NAN    = out_e.nan;
  assign bus.R_INF    = out_e.inf;
  assign bus.R_ZERO   = out_e.zero;
  assign bus.COUNT    = cnt;
  assign bus.DROP_CNT = drop;
  assign bus.ERR_CNT  = err;
endmodule

// File: doc/fpmul_result_q.md
Name: fpmul_result_q

Overview:
Downstream result stage for the sequential FP32 multiplier. It captures each packaged product word plus underflow/overflow flags when the multiplier pulses Done. Results are queued in a small FIFO, tagged with an IEEE-754 class decode, and presented to the consumer over a valid/ready interface. It also issues start credit back to the multiplier issue side, so a multiply is never launched without a guaranteed result slot.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
CNT_W, 8, width of drop/error counters (saturating)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
Start  in  1  start pulse sent to multiplier controller (monitored here)
Start_OK  out  1  credit: high when a Start would be accepted
Done  in  1  multiplier completion pulse (1 cycle)
P  in  32  packaged product {sign, exp[7:0], mant[22:0]}, valid when Done=1
UF  in  1  underflow flag, valid when Done=1
OF  in  1  overflow flag, valid when Done=1
R_VALID  out  1  head entry valid
R_READY  in  1  consumer accepts head
R_DATA  out  32  head product
R_UF  out  1  head underflow flag
R_OF  out  1  head overflow flag
R_NAN  out  1  head is NaN
R_INF  out  1  head is +/-Inf
R_ZERO  out  1  head is +/-0
COUNT  out  $clog2(DEPTH)+1  occupied entries
DROP_CNT  out  CNT_W  results lost to overflow
ERR_CNT  out  CNT_W  protocol violations

Behaviour:
- Reset (async assert, sync deassert use): state IDLE, FIFO empty, all pointers 0, all outputs 0 except Start_OK=1.
- Issue FSM, two states:
  - IDLE: Start_OK = (COUNT + pending_pop_free) < DEPTH, i.e. COUNT < DEPTH. Start & Start_OK -> WAIT.
  - WAIT: Start_OK=0. Done -> IDLE.
  - Start while Start_OK=0 (in IDLE or WAIT): ERR_CNT+1, no state change.
  - Done in IDLE (spurious): result still pushed if space, ERR_CNT+1.
- Push on Done. The entry stores P, UF, OF and a class decode of P:
  - NaN = exp==8'hFF && mant!=0
  - Inf = exp==8'hFF && mant==0
  - Zero = exp==8'h00 (denormals are flushed, so any exp 0 counts as zero)
  - Class bits are mutually exclusive.
- Pop on R_VALID & R_READY.
- Latency: Done in cycle n -> R_VALID=1 in cycle n+1, with fields registered.
- R_VALID = COUNT!=0. Head fields are stable while R_VALID=1 and R_READY=0. Fields hold their last value when empty.
- Simultaneous push and pop:
  - Not empty: COUNT unchanged, both applied.
  - Full: the pop frees the slot and the push is accepted, no drop.
- Push while full without pop: result discarded, DROP_CNT+1. This is unreachable when credit is honoured.
- Pointers wrap modulo DEPTH. COUNT range is 0..DEPTH.
- Counters saturate at all-ones and are not cleared except by reset.
- Reset mid-operation (WAIT or non-empty): everything is cleared immediately. An in-flight Done after reset counts as spurious.

Optional Feature:
Macro FPMUL_RQ_BYPASS_EN.
- Defined: when the FIFO is empty and Done=1, R_VALID and the fields are driven combinationally from P/UF/OF/decode in the same cycle. If R_READY=1 in that cycle, the entry is consumed and never written (COUNT stays 0). Otherwise it is pushed normally.
- Undefined: fixed 1-cycle latency, R_* are fully registered outputs.

Test Plan:
1. Reset, Start=1, Done after 8 cycles with P=0x40C00000 (3.0*2.0), UF=OF=0, R_READY=1 -> R_VALID next cycle, R_DATA=0x40C00000, all class bits 0, COUNT returns to 0, Start_OK back to 1.
2. Four results with R_READY=0: P=0x7FC00000, 0x7F800000, 0x80000000, 0x3F800000 -> R_NAN, R_INF, R_ZERO, none set in FIFO order; COUNT=4, Start_OK=0. Then drain in order.
3. FIFO full and a Start pulse -> ERR_CNT=1, state stays IDLE. Forced Done while full with R_READY=0 -> DROP_CNT=1, COUNT=4. Done with R_READY=1 -> no drop.
4. Done with OF=1, P=0x7F800000 -> R_OF=1, R_INF=1. Done with UF=1, P=0x00000000 -> R_UF=1, R_ZERO=1.
5. Assert rst_n=0 mid-WAIT with COUNT=2 -> same-cycle async clear: R_VALID=0, COUNT=0, Start_OK=1. A later Done increments ERR_CNT.
6. Build with FPMUL_RQ_BYPASS_EN, empty FIFO, R_READY=1, Done with P=0x41200000 -> R_VALID=1 and R_DATA=0x41200000 in the Done cycle, COUNT stays 0.
